// File: rtl/dec_pkg.sv
// Shared types and constants for the decimal conversion path.
// Used by bcd_digit_adj and dec_conv_arb.
package dec_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int DIGIT_W    = 4;
    localparam int ADJ_THRESH = 5;
    localparam int ADJ_ADD    = 3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
    import dec_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q
);

    assign q = (d >= DIGIT_W'(ADJ_THRESH)) ? d + DIGIT_W'(ADJ_ADD) : d;

endmodule

// File: rtl/dec_conv_arb.sv
// Time-shared sequential binary-to-BCD converter, two-way round-robin.
// Build option: DEC_SIGNED_EN treats operands as two's complement.
module dec_conv_arb
    import dec_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req0,
    input  logic                      req1,
    input  logic [WIDTH-1:0]          bin_in0,
    input  logic [WIDTH-1:0]          bin_in1,
    output logic                      gnt0,
    output logic                      gnt1,
    output logic                      busy,
    output logic                      done,
    output logic                      done_id,
    output logic [DIGIT_W*DIGITS-1:0] dec_out,
    output logic                      sign_out
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    state_t             state_n;
    logic               last;
    logic               cur_id;
    logic [WIDTH-1:0]   bin_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt;

    logic               accept;
    logic               pick1;
    logic               last_shift;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   operand_mag;

    logic [BCD_W+WIDTH-1:0] shifted;
    logic [BCD_W-1:0]       bcd_next;
    logic [WIDTH-1:0]       bin_next;

    assign accept     = (state == IDLE) && (req0 || req1);
    // On a tie the requester that was not served last wins.
    assign pick1      = req1 && (!req0 || !last);
    assign operand    = pick1 ? bin_in1 : bin_in0;
    assign last_shift = (cnt == CNT_W'(1));

`ifdef DEC_SIGNED_EN
    logic operand_neg;
    logic sign_q;

    assign operand_neg = operand[WIDTH-1];
    // Unsigned WIDTH-bit negation is exact for the most negative value.
    assign operand_mag = operand_neg ? (~operand + 1'b1) : operand;
`else
    assign operand_mag = operand;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (bcd_q[g*DIGIT_W +: DIGIT_W]),
            .q (bcd_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    assign shifted  = {bcd_adj, bin_q} << 1;
    assign bcd_next = shifted[BCD_W+WIDTH-1:WIDTH];
    assign bin_next = shifted[WIDTH-1:0];

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept) state_n = SHIFT;
            SHIFT:   if (last_shift) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            last    <= 1'b1;
            cur_id  <= 1'b0;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt     <= '0;
            dec_out <= '0;
            done_id <= 1'b0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            if (state == IDLE && accept) begin
                gnt0   <= !pick1;
                gnt1   <= pick1;
                last   <= pick1;
                cur_id <= pick1;
                bin_q  <= operand_mag;
                bcd_q  <= '0;
                cnt    <= CNT_W'(WIDTH);
            end else if (state == SHIFT) begin
                bcd_q <= bcd_next;
                bin_q <= bin_next;
                cnt   <= cnt - 1'b1;
                if (last_shift) begin
                    dec_out <= bcd_next;
                    done_id <= cur_id;
                end
            end
        end
    end

`ifdef DEC_SIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q   <= 1'b0;
            sign_out <= 1'b0;
        end else begin
            if (state == IDLE && accept) begin
                sign_q <= operand_neg;
            end
            if (state == SHIFT && last_shift) begin
                sign_out <= sign_q;
            end
        end
    end
`else
    assign sign_out = 1'b0;
`endif

endmodule

// File: tb/tb_dec_conv_arb.sv
// Randomized self-checking bench for dec_conv_arb.
// Expected results come from a decimal-arithmetic reference model.
module tb_dec_conv_arb;

    logic        clk;
    logic        rst_n;
    logic        req0;
    logic        req1;
    logic [15:0] bin_in0;
    logic [15:0] bin_in1;
    logic        gnt0;
    logic        gnt1;
    logic        busy;
    logic        done;
    logic        done_id;
    logic [19:0] dec_out;
    logic        sign_out;

    int passed;
    int total;
    bit exp_last;

    dec_conv_arb #(.WIDTH(16), .DIGITS(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .req1     (req1),
        .bin_in0  (bin_in0),
        .bin_in1  (bin_in1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .busy     (busy),
        .done     (done),
        .done_id  (done_id),
        .dec_out  (dec_out),
        .sign_out (sign_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [19:0] model_dec(input logic [15:0] v);
        int m;
        logic [19:0] r;
        m = int'(v);
`ifdef DEC_SIGNED_EN
        if (v[15]) m = 65536 - m;
`endif
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic model_sign(input logic [15:0] v);
`ifdef DEC_SIGNED_EN
        return v[15];
`else
        return 1'b0 & v[0];
`endif
    endfunction

    task automatic run_one(input bit id, input logic [15:0] v,
                           output int gnt_cyc, output int gnt_cnt,
                           output int done_cyc, output logic [19:0] dec,
                           output logic did, output logic sgn,
                           output logic done_after);
        gnt_cyc  = -1;
        gnt_cnt  = 0;
        done_cyc = -1;
        dec      = 'x;
        did      = 1'bx;
        sgn      = 1'bx;
        if (id) begin
            bin_in1 = v;
            req1    = 1'b1;
        end else begin
            bin_in0 = v;
            req0    = 1'b1;
        end
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (id ? gnt1 : gnt0) begin
                gnt_cnt++;
                if (gnt_cyc < 0) gnt_cyc = c;
                req0 = 1'b0;
                req1 = 1'b0;
            end
            if (done) begin
                done_cyc = c;
                dec      = dec_out;
                did      = done_id;
                sgn      = sign_out;
                break;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk);
        #1;
        done_after = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        bin_in0 = '0;
        bin_in1 = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({gnt0, gnt1, busy, done} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b want 0000", {gnt0, gnt1, busy, done});
        else passed++;
        total++;
        if ({done_id, sign_out, dec_out} !== 22'h0)
            $display("FAIL reset_data: got %h want 0", {done_id, sign_out, dec_out});
        else passed++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_last = 1'b1;
    endtask

    task automatic test_tie();
        int g_id[$];
        int g_cyc[$];
        int d_cyc[$];
        logic [19:0] d_dec[$];
        logic d_id[$];
        bin_in0 = 16'd65535;
        bin_in1 = 16'd99;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int c = 1; c <= 80 && d_cyc.size() < 2; c++) begin
            @(posedge clk);
            #1;
            if (gnt0) begin g_id.push_back(0); g_cyc.push_back(c); req0 = 1'b0; end
            if (gnt1) begin g_id.push_back(1); g_cyc.push_back(c); req1 = 1'b0; end
            if (done) begin
                d_cyc.push_back(c);
                d_dec.push_back(dec_out);
                d_id.push_back(done_id);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        total++;
        if (g_id.size() != 2 || d_cyc.size() != 2) begin
            $display("FAIL tie_count: got %0d grants %0d dones want 2 2",
                     g_id.size(), d_cyc.size());
        end else begin
            passed++;
            total++;
            if (g_id[0] != 0 || g_id[1] != 1 || g_cyc[0] != 1)
                $display("FAIL tie_order: got %0d,%0d at %0d want 0,1 at 1",
                         g_id[0], g_id[1], g_cyc[0]);
            else passed++;
            total++;
            if (d_dec[0] !== model_dec(16'd65535) || d_id[0] !== 1'b0 || d_cyc[0] != 17)
                $display("FAIL tie_first: got %h id %b cyc %0d want %h id 0 cyc 17",
                         d_dec[0], d_id[0], d_cyc[0], model_dec(16'd65535));
            else passed++;
            total++;
            if (d_dec[1] !== model_dec(16'd99) || d_id[1] !== 1'b1 || g_cyc[1] <= d_cyc[0])
                $display("FAIL tie_second: got %h id %b want %h id 1",
                         d_dec[1], d_id[1], model_dec(16'd99));
            else passed++;
        end
        @(posedge clk);
        #1;
        exp_last = 1'b1;
    endtask

    task automatic test_alternate();
        logic [15:0] va;
        logic [15:0] vb;
        int g_id[$];
        int d_cyc[$];
        logic [19:0] d_dec[$];
        logic d_id[$];
        bit want;
        va = 16'($urandom);
        vb = 16'($urandom);
        bin_in0 = va;
        bin_in1 = vb;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int c = 1; c <= 150 && d_cyc.size() < 4; c++) begin
            @(posedge clk);
            #1;
            if (gnt0) g_id.push_back(0);
            if (gnt1) g_id.push_back(1);
            if (g_id.size() >= 4) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            if (done) begin
                d_cyc.push_back(c);
                d_dec.push_back(dec_out);
                d_id.push_back(done_id);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        total++;
        if (g_id.size() != 4 || d_cyc.size() != 4) begin
            $display("FAIL alt_count: got %0d grants %0d dones want 4 4",
                     g_id.size(), d_cyc.size());
        end else begin
            passed++;
            want = !exp_last;
            for (int i = 0; i < 4; i++) begin
                total++;
                if (g_id[i] != int'(want) || d_id[i] !== want ||
                    d_dec[i] !== model_dec(want ? vb : va))
                    $display("FAIL alt_%0d: grant %0d id %b dec %h want id %b dec %h",
                             i, g_id[i], d_id[i], d_dec[i], want,
                             model_dec(want ? vb : va));
                else passed++;
                if (i > 0) begin
                    total++;
                    if (d_cyc[i] - d_cyc[i-1] != 18)
                        $display("FAIL alt_spacing_%0d: got %0d want 18",
                                 i, d_cyc[i] - d_cyc[i-1]);
                    else passed++;
                end
                exp_last = want;
                want = !want;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int seen_done;
        int gc, gn, dc;
        logic [19:0] dv;
        logic di, sg, da;
        seen_done = 0;
        bin_in0 = 16'd54321;
        req0 = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (gnt0) req0 = 1'b0;
        end
        req0 = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || dec_out !== 20'h0 || done !== 1'b0)
            $display("FAIL reset_mid_async: busy %b dec %h done %b want 0 0 0",
                     busy, dec_out, done);
        else passed++;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (c == 2) rst_n = 1'b1;
            if (done) seen_done++;
        end
        total++;
        if (seen_done != 0 || busy !== 1'b0)
            $display("FAIL reset_mid_quiet: got %0d dones busy %b want 0 0",
                     seen_done, busy);
        else passed++;
        exp_last = 1'b1;
        run_one(1'b0, 16'd54321, gc, gn, dc, dv, di, sg, da);
        total++;
        if (dv !== model_dec(16'd54321) || di !== 1'b0 || dc != 17)
            $display("FAIL reset_mid_redo: got %h id %b cyc %0d want %h id 0 cyc 17",
                     dv, di, dc, model_dec(16'd54321));
        else passed++;
    endtask

    task automatic test_single();
        int gc, gn, dc;
        logic [19:0] dv;
        logic di, sg, da;
        run_one(1'b0, 16'd12345, gc, gn, dc, dv, di, sg, da);
        total++;
        if (gc != 1 || gn != 1)
            $display("FAIL single_gnt: got cyc %0d count %0d want 1 1", gc, gn);
        else passed++;
        total++;
        if (dc != 17 || dv !== 20'h12345 || di !== 1'b0 || sg !== 1'b0)
            $display("FAIL single_done: got cyc %0d dec %h id %b sign %b want 17 12345 0 0",
                     dc, dv, di, sg);
        else passed++;
        total++;
        if (da !== 1'b0 || busy !== 1'b0)
            $display("FAIL single_strobe: done %b busy %b want 0 0", da, busy);
        else passed++;
    endtask

    task automatic test_boundary();
        logic [15:0] ops [5];
        logic [19:0] exp_dec [5];
        logic        exp_sgn [5];
        int gc, gn, dc;
        logic [19:0] dv;
        logic di, sg, da;
        ops = '{16'd0, 16'd9, 16'd10, 16'hFFFF, 16'h8000};
`ifdef DEC_SIGNED_EN
        exp_dec = '{20'h00000, 20'h00009, 20'h00010, 20'h00001, 20'h32768};
        exp_sgn = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
        exp_dec = '{20'h00000, 20'h00009, 20'h00010, 20'h65535, 20'h32768};
        exp_sgn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 5; i++) begin
            run_one(i[0], ops[i], gc, gn, dc, dv, di, sg, da);
            total++;
            if (dv !== exp_dec[i] || sg !== exp_sgn[i] || di !== i[0])
                $display("FAIL boundary_%h: got %h sign %b id %b want %h sign %b id %b",
                         ops[i], dv, sg, di, exp_dec[i], exp_sgn[i], i[0]);
            else passed++;
        end
    endtask

    task automatic test_random();
        int gc, gn, dc;
        logic [19:0] dv;
        logic di, sg, da;
        logic [15:0] v;
        bit id;
        for (int i = 0; i < 12; i++) begin
            v  = 16'($urandom);
            id = 1'($urandom_range(0, 1));
            run_one(id, v, gc, gn, dc, dv, di, sg, da);
            total++;
            if (dv !== model_dec(v) || sg !== model_sign(v) || di !== id ||
                dc != 17 || gc != 1)
                $display("FAIL random_%0d: op %h got %h sign %b id %b cyc %0d want %h sign %b id %b cyc 17",
                         i, v, dv, sg, di, dc, model_dec(v), model_sign(v), id);
            else passed++;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_tie();
        test_alternate();
        test_reset_mid();
        test_single();
        test_boundary();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
